// File: rtl/bip_control_unit_pkg.sv
// Shared BIP control-unit definitions: instruction format, opcodes, FSM state codes.
// Pure constants, no latency; no flow control.
package bip_control_unit_pkg;

    localparam int INSTR_BITS = 16;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [1:0] SEL_A_MEM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

endpackage

// File: rtl/bip_control_unit_decoder.sv
// Opcode to datapath control bundle; unknown opcodes decode as NOP.
// Purely combinational, zero latency; no flow control.
module bip_instruction_decoder
    import bip_control_unit_pkg::*;
#(
    parameter int OPCODE_BITS = 5
) (
    input  logic [OPCODE_BITS-1:0] opcode,
    output logic [1:0]             sel_a,
    output logic                   sel_b,
    output logic                   operation,
    output logic                   wr_acc,
    output logic                   wr_ram,
    output logic                   rd_ram,
    output logic                   is_halt
);

    always_comb begin
        sel_a     = SEL_A_MEM;
        sel_b     = 1'b0;
        operation = 1'b0;
        wr_acc    = 1'b0;
        wr_ram    = 1'b0;
        rd_ram    = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            OP_HLT:  is_halt = 1'b1;
            OP_STO:  wr_ram  = 1'b1;
            OP_LD: begin
                wr_acc = 1'b1;
                rd_ram = 1'b1;
            end
            OP_LDI: begin
                sel_a  = SEL_A_IMM;
                sel_b  = 1'b1;
                wr_acc = 1'b1;
            end
            OP_ADD: begin
                sel_a  = SEL_A_ALU;
                wr_acc = 1'b1;
                rd_ram = 1'b1;
            end
            OP_ADDI: begin
                sel_a  = SEL_A_ALU;
                sel_b  = 1'b1;
                wr_acc = 1'b1;
            end
            OP_SUB: begin
                sel_a     = SEL_A_ALU;
                operation = 1'b1;
                wr_acc    = 1'b1;
                rd_ram    = 1'b1;
            end
            OP_SUBI: begin
                sel_a     = SEL_A_ALU;
                sel_b     = 1'b1;
                operation = 1'b1;
                wr_acc    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: fetch/decode/exec sequencer driving the accumulator datapath and data RAM.
// 3 clk per instruction (program memory read takes 1 clk); HALT waits for i_start, no backpressure.
module bip_control_unit
    import bip_control_unit_pkg::*;
#(
    parameter int PC_BITS      = 11,
    parameter int ADDRESS_BITS = 11,
    parameter int OPCODE_BITS  = 5,
    parameter int COUNT_BITS   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [INSTR_BITS-1:0]   i_instruction,
    output logic [PC_BITS-1:0]      o_pc,
    output logic [ADDRESS_BITS-1:0] o_operand,
    output logic [1:0]              o_sel_a,
    output logic                    o_sel_b,
    output logic                    o_write_acc,
    output logic                    o_operation,
    output logic                    o_wr_ram,
    output logic                    o_rd_ram,
    output logic                    o_halted,
    output logic [COUNT_BITS-1:0]   o_cycle_count
);

    localparam logic [PC_BITS-1:0]    PC_ONE  = PC_BITS'(1);
    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

    logic [2:0]              state;
    logic [PC_BITS-1:0]      pc;
    logic [INSTR_BITS-1:0]   ir;
    logic [COUNT_BITS-1:0]   count;

    logic [INSTR_BITS-1:0]   dec_instr;
    logic [1:0]              dec_sel_a;
    logic                    dec_sel_b;
    logic                    dec_operation;
    logic                    dec_wr_acc;
    logic                    dec_wr_ram;
    logic                    dec_rd_ram;
    logic                    dec_is_halt;
    logic                    in_decode_exec;
    logic                    in_exec;
    logic                    counting;

    // IR only lands at the end of DECODE, so during DECODE the freshly read
    // word is decoded directly; EXEC always uses the registered copy.
    assign dec_instr      = (state == ST_EXEC) ? ir : i_instruction;
    assign in_decode_exec = (state == ST_DECODE) || (state == ST_EXEC);
    assign in_exec        = (state == ST_EXEC);
    assign counting       = (state == ST_FETCH) || in_decode_exec;

    bip_instruction_decoder #(
        .OPCODE_BITS (OPCODE_BITS)
    ) u_decoder (
        .opcode    (dec_instr[ADDRESS_BITS +: OPCODE_BITS]),
        .sel_a     (dec_sel_a),
        .sel_b     (dec_sel_b),
        .operation (dec_operation),
        .wr_acc    (dec_wr_acc),
        .wr_ram    (dec_wr_ram),
        .rd_ram    (dec_rd_ram),
        .is_halt   (dec_is_halt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            count <= '0;
        end else begin
            if (counting && (count != '1)) begin
                count <= count + CNT_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        pc    <= '0;
                        count <= '0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    ir    <= i_instruction;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    pc    <= pc + PC_ONE;
                    state <= dec_is_halt ? ST_HALT : ST_FETCH;
                end
                ST_HALT: begin
                    if (i_start) begin
                        pc    <= '0;
                        count <= '0;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_pc          = pc;
    assign o_operand     = in_decode_exec ? dec_instr[ADDRESS_BITS-1:0] : '0;
    assign o_sel_a       = in_decode_exec ? dec_sel_a : SEL_A_MEM;
    assign o_sel_b       = in_decode_exec & dec_sel_b;
    assign o_operation   = in_decode_exec & dec_operation;
    assign o_rd_ram      = in_decode_exec & dec_rd_ram;
    assign o_write_acc   = in_exec & dec_wr_acc;
    assign o_wr_ram      = in_exec & dec_wr_ram;
    assign o_halted      = (state == ST_HALT);
    assign o_cycle_count = count;

endmodule

// File: tb/tb_bip_control_unit.sv
// Randomized scoreboard bench for bip_control_unit (PC_BITS=4, 16-word program memory).
module tb_bip_control_unit;

    localparam int PCB = 4;
    localparam int NPROG = 1 << PCB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_instruction = 16'h0;
    logic [PCB-1:0] o_pc;
    logic [10:0] o_operand;
    logic [1:0]  o_sel_a;
    logic        o_sel_b, o_write_acc, o_operation, o_wr_ram, o_rd_ram, o_halted;
    logic [31:0] o_cycle_count;

    bip_control_unit #(.PC_BITS(PCB), .ADDRESS_BITS(11), .OPCODE_BITS(5), .COUNT_BITS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_instruction (i_instruction),
        .o_pc          (o_pc),
        .o_operand     (o_operand),
        .o_sel_a       (o_sel_a),
        .o_sel_b       (o_sel_b),
        .o_write_acc   (o_write_acc),
        .o_operation   (o_operation),
        .o_wr_ram      (o_wr_ram),
        .o_rd_ram      (o_rd_ram),
        .o_halted      (o_halted),
        .o_cycle_count (o_cycle_count)
    );

    always #5 clk = ~clk;

    logic [15:0] prog [NPROG];
    always @(posedge clk) i_instruction <= prog[o_pc];

    typedef struct {
        int          phase;   // 0 fetch, 1 decode, 2 exec, 3 halt
        int          idx;
        logic [PCB-1:0] pc;
        logic [10:0] operand;
        logic [1:0]  sel_a;
        logic        sel_b, op, wr_acc, wr_ram, rd_ram, halted;
        logic [31:0] count;
        bit          chk_pc, chk_sel;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Control table straight from the opcode list, indexed by opcode 0..7.
    int sa_t[8] = '{0, 0, 0, 1, 2, 2, 2, 2};
    int sb_t[8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    int op_t[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int wa_t[8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    int wr_t[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    int rd_t[8] = '{0, 0, 1, 0, 1, 0, 1, 0};

    function automatic string phase_name(input int p);
        case (p)
            0: return "fetch";
            1: return "decode";
            2: return "exec";
            default: return "halt";
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            bit ok;
            e = exp_q.pop_front();
            checks++;
            ok = (!e.chk_pc || o_pc == e.pc) && (o_operand == e.operand) &&
                 (!e.chk_sel || (o_sel_a == e.sel_a && o_sel_b == e.sel_b && o_operation == e.op)) &&
                 (o_write_acc == e.wr_acc) && (o_wr_ram == e.wr_ram) && (o_rd_ram == e.rd_ram) &&
                 (o_halted == e.halted) && (o_cycle_count == e.count);
            if (!ok) begin
                errors++;
                $display("FAIL trace[%0d.%s]: got pc=%0d opnd=%h sa=%0d sb=%0d op=%0d wa=%0d wr=%0d rd=%0d h=%0d cnt=%0d; want pc=%0d opnd=%h sa=%0d sb=%0d op=%0d wa=%0d wr=%0d rd=%0d h=%0d cnt=%0d",
                         e.idx, phase_name(e.phase), o_pc, o_operand, o_sel_a, o_sel_b, o_operation,
                         o_write_acc, o_wr_ram, o_rd_ram, o_halted, o_cycle_count,
                         e.pc, e.operand, e.sel_a, e.sel_b, e.op, e.wr_acc, e.wr_ram, e.rd_ram, e.halted, e.count);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Reference model: walk the program instruction by instruction from PC 0.
    task automatic gen_trace(input int max_instr, input int halt_cycles);
        int pc = 0;
        int cnt = 0;
        for (int n = 0; n < max_instr; n++) begin
            exp_t e;
            logic [4:0] opc;
            int k;
            bit known;
            opc = prog[pc][15:11];
            known = (opc >= 1 && opc <= 7);
            k = (opc < 8) ? int'(opc) : 0;
            e = '{phase: 0, idx: n, pc: PCB'(pc), operand: 11'h0, sel_a: 2'd0, sel_b: 1'b0, op: 1'b0,
                  wr_acc: 1'b0, wr_ram: 1'b0, rd_ram: 1'b0, halted: 1'b0, count: 32'(cnt),
                  chk_pc: 1'b1, chk_sel: 1'b0};
            exp_q.push_back(e);
            e.phase   = 1;
            e.operand = prog[pc][10:0];
            e.sel_a   = 2'(sa_t[k]);
            e.sel_b   = 1'(sb_t[k]);
            e.op      = 1'(op_t[k]);
            e.rd_ram  = (opc < 8) ? 1'(rd_t[k]) : 1'b0;
            e.chk_sel = known;
            e.count   = 32'(cnt + 1);
            exp_q.push_back(e);
            e.phase   = 2;
            e.wr_acc  = (opc < 8) ? 1'(wa_t[k]) : 1'b0;
            e.wr_ram  = (opc < 8) ? 1'(wr_t[k]) : 1'b0;
            e.count   = 32'(cnt + 2);
            exp_q.push_back(e);
            cnt += 3;
            pc = (pc + 1) % NPROG;
            if (opc == 5'b00000) begin
                for (int h = 0; h < halt_cycles; h++) begin
                    e = '{phase: 3, idx: n, pc: '0, operand: 11'h0, sel_a: 2'd0, sel_b: 1'b0, op: 1'b0,
                          wr_acc: 1'b0, wr_ram: 1'b0, rd_ram: 1'b0, halted: 1'b1, count: 32'(cnt),
                          chk_pc: 1'b0, chk_sel: 1'b1};
                    exp_q.push_back(e);
                end
                break;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected cycles never observed, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("reset_pc", 32'(o_pc), 0);
        chk("reset_count", o_cycle_count, 0);
        chk("reset_ctrl", {21'h0, o_operand, o_sel_a, o_sel_b, o_write_acc, o_operation, o_wr_ram, o_rd_ram, o_halted} , 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic run(input int max_instr, input int halt_cycles);
        pulse_start();
        gen_trace(max_instr, halt_cycles);
        drain();
    endtask

    task automatic fill_nop();
        for (int i = 0; i < NPROG; i++) prog[i] = {5'(8 + $urandom_range(0, 23)), 11'($urandom)};
    endtask

    initial begin
        fill_nop();
        #2;
        chk("init_reset_halted", 32'(o_halted), 0);
        chk("init_reset_count", o_cycle_count, 0);
        #20 rst = 1'b0;

        // LDI 5; ADDI 3; STO 7; HLT -> 12 counted clocks then halted.
        prog[0] = {5'b00011, 11'd5};
        prog[1] = {5'b00101, 11'd3};
        prog[2] = {5'b00001, 11'd7};
        prog[3] = {5'b00000, 11'd0};
        do_reset();
        run(10, 3);

        // SUBI with all-ones operand.
        fill_nop();
        prog[0] = {5'b00111, 11'h7FF};
        prog[1] = {5'b00000, 11'h0};
        do_reset();
        run(10, 2);

        // Unknown opcode behaves as NOP and PC advances.
        fill_nop();
        prog[0] = {5'b11111, 11'h2A5};
        prog[1] = {5'b00000, 11'h0};
        do_reset();
        run(10, 2);

        // All-NOP memory: PC wraps after 16 instructions, count 48 at the 17th fetch.
        fill_nop();
        do_reset();
        run(18, 0);

        // Reset in the middle of a STO execute cycle.
        fill_nop();
        prog[0] = {5'b00001, 11'h123};
        do_reset();
        pulse_start();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("sto_exec_wr_ram", 32'(o_wr_ram), 1);
        chk("sto_exec_operand", 32'(o_operand), 32'h123);
        rst = 1'b1;
        #1;
        chk("midexec_rst_wr_ram", 32'(o_wr_ram), 0);
        chk("midexec_rst_pc", 32'(o_pc), 0);
        chk("midexec_rst_count", o_cycle_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("after_rst_idle_count", o_cycle_count, 0);
        chk("after_rst_idle_wr_ram", 32'(o_wr_ram), 0);

        // Start pulses during a run are ignored; start in HALT restarts at PC 0.
        fill_nop();
        prog[4] = {5'b00000, 11'h0};
        do_reset();
        pulse_start();
        gen_trace(10, 4);
        repeat (2) @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        drain();
        run(10, 2);

        // Random programs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NPROG; i++) begin
                int sel;
                logic [4:0] opc;
                sel = $urandom_range(0, 10);
                opc = (sel <= 7) ? 5'(sel) : 5'(8 + $urandom_range(0, 23));
                if (opc == 5'b00000 && $urandom_range(0, 2) != 0) opc = 5'b00101;
                prog[i] = {opc, 11'($urandom)};
            end
            do_reset();
            run(30, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
